// File: rtl/fini_encoder_k4_pkg.sv
// ============================================================================
// Module : fini_encoder_k4_pkg
// Brief  : Shared codeword constants, typedefs and mapping for the FINI encoder
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fini_encoder_k4_pkg;

    localparam int CW_W = 5;

    typedef logic [CW_W-1:0] cw_t;

    // AND of the two codewords maps back onto the AND of the data bits
    localparam cw_t CW_ZERO = 5'b00000;
    localparam cw_t CW_ONE  = 5'b11111;

    // One-hot encoding so any corrupted state is detectable
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_SEND  = 3'b010,
        ST_ERROR = 3'b100
    } state_t;

    function automatic cw_t cw_map(input logic b);
        return b ? CW_ONE : CW_ZERO;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fini_cw_check.sv
// ============================================================================
// Module : fini_cw_check
// Brief  : Combinational codeword membership check, shared with the decoder
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fini_cw_check
    import fini_encoder_k4_pkg::*;
(
    input  cw_t  cw,
    output logic is_zero,
    output logic is_one,
    output logic is_member
);

    assign is_zero   = (cw == CW_ZERO);
    assign is_one    = (cw == CW_ONE);
    assign is_member = is_zero | is_one;

endmodule

`default_nettype wire

// File: rtl/fini_encoder_k4.sv
// ============================================================================
// Module : fini_encoder_k4
// Brief  : Serialises a K-bit word into one codeword per data bit, LSB first
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fini_encoder_k4
    import fini_encoder_k4_pkg::*;
#(
    parameter int K    = 4,
    parameter int CW_W = fini_encoder_k4_pkg::CW_W
) (
    input  logic            port_clk,
    input  logic            port_rst_n,
    input  logic            port_in_valid,
    output logic            port_in_ready,
    input  logic [K-1:0]    port_in_data,
    output logic [CW_W-1:0] port_c,
    output logic            port_c_valid,
    input  logic            port_c_ready,
    output logic            port_c_last,
    output logic            port_errorFlag
);

    localparam int IDX_W = $clog2(K);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [K-1:0]     r_shreg;
    logic [IDX_W-1:0] r_idx;
    cw_t              r_c;
    logic             r_err;

    logic w_load;
    logic w_shift;
    logic w_state_bad;
    logic w_idx_bad;
    logic w_cw_zero;
    logic w_cw_one;
    logic w_cw_ok;
    logic w_fault;

    fini_cw_check u_cw_check (
        .cw        (r_c),
        .is_zero   (w_cw_zero),
        .is_one    (w_cw_one),
        .is_member (w_cw_ok)
    );

    // Out-of-range index is only representable when K is not a power of two
    if ((1 << IDX_W) > K) begin : g_idx_chk
        assign w_idx_bad = (r_idx > IDX_W'(K - 1));
    end else begin : g_idx_full
        assign w_idx_bad = 1'b0;
    end

    assign w_state_bad    = !(r_state inside {ST_IDLE, ST_SEND, ST_ERROR});
    assign w_fault        = ~w_cw_ok | w_state_bad | w_idx_bad;
    assign port_errorFlag = r_err;

    always_ff @(posedge port_clk or negedge port_rst_n) begin
        if (!port_rst_n) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
            r_c     <= CW_ZERO;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | w_fault;
            if (w_load) begin
                r_shreg <= port_in_data;
                r_idx   <= '0;
                r_c     <= cw_map(port_in_data[0]);
            end else if (w_shift) begin
                r_shreg <= r_shreg >> 1;
                r_idx   <= r_idx + IDX_W'(1);
                r_c     <= cw_map(r_shreg[1]);
            end else if (w_state_nxt != ST_SEND) begin
                r_c     <= CW_ZERO;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        port_in_ready = 1'b0;
        port_c_valid  = 1'b0;
        port_c        = CW_ZERO;
        port_c_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                port_in_ready = 1'b1;
                if (port_in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                port_c_valid  = 1'b1;
                port_c        = r_c;
                port_c_last   = (r_idx == IDX_W'(K - 1));
                port_in_ready = port_c_last & port_c_ready;
                if (port_c_ready) begin
                    if (!port_c_last) begin
                        w_shift = 1'b1;
                    end else if (port_in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_ERROR;
        endcase
        // A fault overrides any handshake decided above
        if (w_fault) begin
            w_state_nxt = ST_ERROR;
            w_load      = 1'b0;
            w_shift     = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fini_encoder_k4.sv
// ============================================================================
// Module : tb_fini_encoder_k4
// Brief  : Self-checking bench for fini_encoder_k4 with a queue-based model
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fini_encoder_k4;

    localparam int K    = 4;
    localparam int CW_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [K-1:0]    in_data;
    logic [K-1:0]    b_data;
    logic            c_ready;
    logic            in_ready, b_in_ready;
    logic [CW_W-1:0] c, b_c;
    logic            c_valid, b_c_valid;
    logic            c_last, b_c_last;
    logic            err_flag, b_err_flag;
    logic [CW_W-1:0] prod;
    logic            p_zero, p_one, p_member;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fini_encoder_k4 #(.K(K), .CW_W(CW_W)) dut (
        .port_clk       (clk),
        .port_rst_n     (rst_n),
        .port_in_valid  (in_valid),
        .port_in_ready  (in_ready),
        .port_in_data   (in_data),
        .port_c         (c),
        .port_c_valid   (c_valid),
        .port_c_ready   (c_ready),
        .port_c_last    (c_last),
        .port_errorFlag (err_flag)
    );

    // Second encoder shares the handshake controls but carries its own data
    fini_encoder_k4 #(.K(K), .CW_W(CW_W)) dut_b (
        .port_clk       (clk),
        .port_rst_n     (rst_n),
        .port_in_valid  (in_valid),
        .port_in_ready  (b_in_ready),
        .port_in_data   (b_data),
        .port_c         (b_c),
        .port_c_valid   (b_c_valid),
        .port_c_ready   (c_ready),
        .port_c_last    (b_c_last),
        .port_errorFlag (b_err_flag)
    );

    assign prod = c & b_c;

    fini_cw_check u_prod_chk (
        .cw        (prod),
        .is_zero   (p_zero),
        .is_one    (p_one),
        .is_member (p_member)
    );

    function automatic logic [CW_W-1:0] cw_of(input logic b);
        return b ? 5'b11111 : 5'b00000;
    endfunction

    task automatic cycle(input logic v, input logic [K-1:0] d, input logic r);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        c_ready  = r;
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = '0; b_data = '0; c_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (c_valid !== 1'b0) begin failures++; $display("FAIL reset_c_valid: got %b expected 0", c_valid); end
        checks++; if (c !== 5'b00000) begin failures++; $display("FAIL reset_c: got %b expected 00000", c); end
        checks++; if (c_last !== 1'b0) begin failures++; $display("FAIL reset_c_last: got %b expected 0", c_last); end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_flag); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word(input logic [K-1:0] d);
        cycle(1'b1, d, 1'b1);
        for (int i = 0; i < K; i++) begin
            cycle(1'b0, '0, 1'b1);
            checks++; if (c_valid !== 1'b1) begin failures++; $display("FAIL word_valid[%0d]: got %b expected 1", i, c_valid); end
            checks++; if (c !== cw_of(d[i])) begin failures++; $display("FAIL word_c[%0d]: got %b expected %b", i, c, cw_of(d[i])); end
            checks++; if (c_last !== (i == K - 1)) begin failures++; $display("FAIL word_last[%0d]: got %b expected %b", i, c_last, (i == K - 1)); end
        end
        cycle(1'b0, '0, 1'b1);
        checks++; if (c_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL word_idle: valid %b ready %b expected 0 1", c_valid, in_ready); end
    endtask

    task automatic test_stall();
        logic [K-1:0] d = 4'b0110;
        cycle(1'b1, d, 1'b1);
        for (int i = 0; i < K; i++) begin
            int stalls = (i == 1) ? 3 : 0;
            for (int s = 0; s <= stalls; s++) begin
                cycle(1'b0, '0, (s == stalls));
                checks++;
                if (c_valid !== 1'b1 || c !== cw_of(d[i]) || c_last !== (i == K - 1)) begin
                    failures++;
                    $display("FAIL stall[%0d.%0d]: got v=%b c=%b l=%b expected v=1 c=%b l=%b",
                             i, s, c_valid, c, c_last, cw_of(d[i]), (i == K - 1));
                end
            end
        end
        cycle(1'b0, '0, 1'b1);
        checks++; if (c_valid !== 1'b0) begin failures++; $display("FAIL stall_idle: got %b expected 0", c_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2*K-1:0] bits = {4'h0, 4'hF};
        cycle(1'b1, 4'hF, 1'b1);
        for (int i = 0; i < 2 * K; i++) begin
            cycle(i < K, 4'h0, 1'b1);
            checks++;
            if (c_valid !== 1'b1 || c !== cw_of(bits[i]) || c_last !== (i % K == K - 1) ||
                in_ready !== (i % K == K - 1)) begin
                failures++;
                $display("FAIL b2b[%0d]: got v=%b c=%b l=%b r=%b expected v=1 c=%b l=%b r=%b",
                         i, c_valid, c, c_last, in_ready, cw_of(bits[i]), (i % K == K - 1), (i % K == K - 1));
            end
        end
        cycle(1'b0, '0, 1'b1);
        checks++; if (c_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b expected 0", c_valid); end
    endtask

    task automatic test_random();
        logic [CW_W:0] q[$];
        logic v, r, exp_ready;
        logic [K-1:0] d;
        int budget;
        for (int n = 0; n < 400; n++) begin
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            d = K'($urandom);
            cycle(v, d, r);
            exp_ready = (q.size() == 0) || (q.size() == 1 && r);
            checks++; if (c_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, c_valid, (q.size() != 0)); end
            checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, in_ready, exp_ready); end
            if (q.size() != 0) begin
                checks++;
                if ({c_last, c} !== q[0]) begin
                    failures++;
                    $display("FAIL rand_cw[%0d]: got l=%b c=%b expected l=%b c=%b", n, c_last, c, q[0][CW_W], q[0][CW_W-1:0]);
                end
                if (r) void'(q.pop_front());
            end
            if (v && exp_ready)
                for (int i = 0; i < K; i++) q.push_back({(i == K - 1), cw_of(d[i])});
        end
        budget = 4 * K;
        while (q.size() != 0 && budget > 0) begin
            cycle(1'b0, '0, 1'b1);
            checks++;
            if (c_valid !== 1'b1 || {c_last, c} !== q[0]) begin
                failures++;
                $display("FAIL rand_drain: got v=%b l=%b c=%b expected v=1 l=%b c=%b", c_valid, c_last, c, q[0][CW_W], q[0][CW_W-1:0]);
            end
            void'(q.pop_front());
            budget--;
        end
        cycle(1'b0, '0, 1'b1);
        checks++; if (c_valid !== 1'b0 || err_flag !== 1'b0) begin failures++; $display("FAIL rand_end: valid %b err %b expected 0 0", c_valid, err_flag); end
    endtask

    task automatic test_reset_midword();
        cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || c_valid !== 1'b0 || c !== 5'b00000 || c_last !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got r=%b v=%b c=%b l=%b expected 1 0 00000 0", in_ready, c_valid, c, c_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_single_word(4'b0001);
    endtask

    task automatic test_and_product();
        logic [K-1:0] a, b;
        for (int p = 0; p < 6; p++) begin
            a = K'($urandom);
            b = K'($urandom);
            b_data = b;
            cycle(1'b1, a, 1'b1);
            for (int i = 0; i < K; i++) begin
                cycle(1'b0, '0, 1'b1);
                checks++; if (prod !== cw_of(a[i] & b[i])) begin failures++; $display("FAIL and_prod[%0d.%0d]: got %b expected %b", p, i, prod, cw_of(a[i] & b[i])); end
                checks++;
                if (p_member !== 1'b1 || p_one !== (a[i] & b[i])) begin
                    failures++;
                    $display("FAIL and_decode[%0d.%0d]: got member=%b one=%b expected 1 %b", p, i, p_member, p_one, a[i] & b[i]);
                end
            end
            cycle(1'b0, '0, 1'b1);
        end
        checks++; if (err_flag !== 1'b0 || b_err_flag !== 1'b0) begin failures++; $display("FAIL and_err: got %b %b expected 0 0", err_flag, b_err_flag); end
        b_data = '0;
    endtask

    task automatic test_error();
        @(negedge clk);
        force dut.r_c = 5'b00001;
        @(posedge clk);
        #1;
        release dut.r_c;
        checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL err_flag: got %b expected 1", err_flag); end
        checks++; if (c_valid !== 1'b0 || in_ready !== 1'b0 || c !== 5'b00000) begin failures++; $display("FAIL err_outputs: got v=%b r=%b c=%b expected 0 0 00000", c_valid, in_ready, c); end
        for (int n = 0; n < 6; n++) begin
            cycle(1'b1, 4'hA, 1'b1);
            checks++;
            if (err_flag !== 1'b1 || c_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL err_sticky[%0d]: got e=%b v=%b r=%b expected 1 0 0", n, err_flag, c_valid, in_ready);
            end
        end
        test_reset();
        checks++; if (err_flag !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL err_cleared: got e=%b r=%b expected 0 1", err_flag, in_ready); end
    endtask

    initial begin
        test_reset();
        test_single_word(4'b1011);
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_midword();
        test_and_product();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fini_encoder_k4.md
FINI_ENCODER_K4 -- requirements
Module: fini_encoder_k4

Interface
REQ-001 SHALL have parameter K, default 4, giving the number of data bits per input word (K >= 2).
REQ-002 SHALL have parameter CW_W, default 5, giving the codeword width.
REQ-003 SHALL have port_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port_rst_n, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port_in_valid, input, 1, which qualifies port_in_data.
REQ-006 SHALL have port_in_ready, output, 1; the block accepts a word in any cycle with port_in_valid and port_in_ready both high.
REQ-007 SHALL have port_in_data, input, K, the plain data word; bit 0 SHALL be encoded first.
REQ-008 SHALL have port_c, output, CW_W, the current codeword.
REQ-009 SHALL have port_c_valid, output, 1, which qualifies port_c.
REQ-010 SHALL have port_c_ready, input, 1; a codeword transfers in any cycle with port_c_valid and port_c_ready both high.
REQ-011 SHALL have port_c_last, output, 1, high with the codeword of data bit K-1.
REQ-012 SHALL have port_errorFlag, output, 1, a sticky, registered fault indication.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND and ERROR, with a one-hot or otherwise self-checking state encoding.
REQ-014 In IDLE: port_in_ready=1, port_c_valid=0 and port_c=CW_ZERO.
REQ-015 In IDLE, a handshake on the input SHALL load port_in_data into the shift register, clear the index counter ($clog2(K) bits) and move the FSM to SEND.
REQ-016 In SEND: port_c_valid=1, port_c = shreg[0] ? CW_ONE : CW_ZERO, and port_c_last = (idx == K-1).
REQ-017 Latency SHALL be 1 cycle from the input handshake to the first valid codeword.
REQ-018 While port_c_valid=1 and port_c_ready=0, port_c, port_c_valid and port_c_last SHALL hold stable.
REQ-019 On an output handshake with last=0, the block SHALL shift shreg right by one and increment idx.
REQ-020 In SEND, port_in_ready SHALL equal port_c_last AND port_c_ready (combinational), allowing back-to-back words.
REQ-021 On an output handshake with last=1 and a simultaneous input handshake, the block SHALL load the new word, clear idx and stay in SEND with no bubble.
REQ-022 On an output handshake with last=1 and no input handshake, the FSM SHALL return to IDLE.
REQ-023 The index counter SHALL never wrap past K-1.
REQ-024 Self-check: every cycle, the registered codeword SHALL be compared against CW_ZERO and CW_ONE.
REQ-025 Any self-check mismatch, illegal FSM state, or idx > K-1 SHALL set port_errorFlag on the next edge and move the FSM to ERROR.
REQ-026 In ERROR: port_errorFlag=1, port_c_valid=0, port_in_ready=0, port_c=CW_ZERO; ERROR SHALL be left only by reset.
REQ-027 Input data offered while port_in_ready=0 SHALL be ignored, with no state change.

Reset
REQ-028 Asserting port_rst_n low SHALL asynchronously force IDLE, shreg=0, idx=0 and port_errorFlag=0.
REQ-029 Reset asserted mid-word SHALL discard the remaining bits; no partial word resumes after reset.
REQ-030 Outputs after reset SHALL be port_in_ready=1, port_c_valid=0, port_c=5'b00000, port_c_last=0 and port_errorFlag=0.

Structure
REQ-031 A shared package SHALL hold CW_W, CW_ZERO=5'b00000, CW_ONE=5'b11111, the state typedef and the codeword typedef.
REQ-032 The codeword membership check SHALL be one sub-module, fini_cw_check, which is combinational and reused by the decode side.
REQ-033 The codeword mapping SHALL be AND-homomorphic: CW_ONE & CW_ONE = CW_ONE and CW_x & CW_ZERO = CW_ZERO.

Verification
REQ-034 Reset, then data 4'b1011 with port_c_ready=1 -> port_c sequence 11111, 11111, 00000, 11111; last high on the 4th codeword only; IDLE afterwards.
REQ-035 Data 4'b0110 with port_c_ready held low for 3 cycles on the 2nd codeword -> 11111 held stable for 3 cycles; sequence 00000, 11111, 11111, 00000.
REQ-036 Words 4'hF then 4'h0 with port_in_valid held high -> 8 consecutive valid codewords with no bubble; port_in_ready pulses with each last.
REQ-037 Force the codeword register to 5'b00001 -> port_errorFlag=1 on the next edge; port_c_valid and port_in_ready go 0 and stay 0 until reset.
REQ-038 Assert port_rst_n low after the 2nd codeword of 4'b1111 -> immediate IDLE; the next word 4'b0001 yields 11111, 00000, 00000, 00000.
REQ-039 Feed both encoder outputs into the AND multiplier and detector -> the product decodes to the bitwise AND of the inputs with no error flagged.
